score_display: RTL and testbench

//  Consumer side of the score counters. Snapshots both players' scores once per frame.

---
 rtl/score_display.sv | 116 +++++++++++
 tb/tb_score_display.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/score_display.sv
// score_display: per-frame score snapshot rendered as blinking two-digit segment glyphs.
module score_display #(
  parameter logic [8:0] P1_X        = 9'd136,
  parameter logic [8:0] P2_X        = 9'd264,
  parameter logic [8:0] SCORE_Y     = 9'd16,
  parameter logic [8:0] DIGIT_SPACE = 9'd24,
  parameter int         BLINK_LOG2  = 5
) (
  input  logic       clk7_159,
  input  logic       rst,
  input  logic       pix_ce,
  input  logic [8:0] hcnt,
  input  logic [8:0] vcnt,
  input  logic       vblank,
  input  logic       s1a,
  input  logic       s1b,
  input  logic       s1c,
  input  logic       s1d,
  input  logic       s1e,
  input  logic       s2a,
  input  logic       s2b,
  input  logic       s2c,
  input  logic       s2d,
  input  logic       s2e,
  input  logic       game_over,
  output logic       score_vid
);
  logic [4:0] snap1_q, snap2_q;
  logic [BLINK_LOG2-1:0] frame_cnt_q;
  logic vblank_q, vb_edge, blank;
  logic [8:0] cx [4];
  logic [8:0] dx [4];
  logic [8:0] dy;
  logic hit_d, hit_q, tens_d, tens_q;
  logic [3:0] dig_d, dig_q;
  logic [1:0] col_d, col_q;
  logic [2:0] row_d, row_q;
  logic [6:0] seg;
  logic on, score_vid_d, score_vid_q;
  assign vb_edge = vblank & ~vblank_q;
  assign blank = game_over & frame_cnt_q[BLINK_LOG2-1];
  assign dy = vcnt - SCORE_Y;
  assign row_d = dy[4:2];
  always_comb begin
    cx[0] = P1_X;
    cx[1] = P1_X + DIGIT_SPACE;
    cx[2] = P2_X;
    cx[3] = P2_X + DIGIT_SPACE;
    hit_d = 1'b0;
    tens_d = 1'b0;
    dig_d = 4'd0;
    col_d = 2'd0;
    for (int i = 0; i < 4; i++) begin
      dx[i] = hcnt - cx[i];
      if (dx[i] < 9'd16) begin
        hit_d = dy < 9'd32;
        tens_d = ~i[0];
        dig_d = i[1] ? (i[0] ? snap2_q[3:0] : {3'b0, snap2_q[4]})
                     : (i[0] ? snap1_q[3:0] : {3'b0, snap1_q[4]});
        col_d = dx[i][3:2];
      end
    end
  end
  // seg bit 0..6 = segments a..g
  always_comb begin
    seg = 7'h00;
    if (tens_q) seg = dig_q[0] ? 7'h06 : 7'h00;
    else
      case (dig_q)
        4'd0: seg = 7'h3F;
        4'd1: seg = 7'h06;
        4'd2: seg = 7'h5B;
        4'd3: seg = 7'h4F;
        4'd4: seg = 7'h66;
        4'd5: seg = 7'h6D;
        4'd6: seg = 7'h7D;
        4'd7: seg = 7'h07;
        4'd8: seg = 7'h7F;
        4'd9: seg = 7'h6F;
        default: seg = 7'h00;
      endcase
  end
  assign on = (seg[0] & row_q == 3'd0) | (seg[1] & col_q == 2'd3 & row_q <= 3'd3)
            | (seg[2] & col_q == 2'd3 & row_q >= 3'd3) | (seg[3] & row_q == 3'd7)
            | (seg[4] & col_q == 2'd0 & row_q >= 3'd3) | (seg[5] & col_q == 2'd0 & row_q <= 3'd3)
            | (seg[6] & row_q == 3'd3);
  assign score_vid_d = hit_q & on & ~blank;
  always_ff @(posedge clk7_159) begin
    if (rst) begin
      snap1_q <= '0;
      snap2_q <= '0;
      frame_cnt_q <= '0;
      vblank_q <= 1'b0;
      hit_q <= 1'b0;
      tens_q <= 1'b0;
      dig_q <= '0;
      col_q <= '0;
      row_q <= '0;
      score_vid_q <= 1'b0;
    end else if (pix_ce) begin
      vblank_q <= vblank;
      if (vb_edge) begin
        snap1_q <= {s1e, s1d, s1c, s1b, s1a};
        snap2_q <= {s2e, s2d, s2c, s2b, s2a};
      end
      frame_cnt_q <= game_over ? frame_cnt_q + {{(BLINK_LOG2-1){1'b0}}, vb_edge} : '0;
      hit_q <= hit_d;
      tens_q <= tens_d;
      dig_q <= dig_d;
      col_q <= col_d;
      row_q <= row_d;
      score_vid_q <= score_vid_d;
    end
  end
  assign score_vid = score_vid_q;
endmodule

// File: tb/tb_score_display.sv
// tb_score_display: scoreboard bench for score_display against a segment-string glyph model.
module tb_score_display;
  logic clk = 1'b0, rst, pce, vb, go, vid;
  logic [8:0] h, v;
  logic [4:0] s1, s2;
  int errs = 0, checks = 0, litc = 0;
  bit q[$];
  logic [4:0] m1, m2, mfc;
  bit mvbq;

  always #5 clk = ~clk;

  score_display dut (
    .clk7_159(clk), .rst(rst), .pix_ce(pce), .hcnt(h), .vcnt(v), .vblank(vb),
    .s1a(s1[0]), .s1b(s1[1]), .s1c(s1[2]), .s1d(s1[3]), .s1e(s1[4]),
    .s2a(s2[0]), .s2b(s2[1]), .s2c(s2[2]), .s2d(s2[3]), .s2e(s2[4]),
    .game_over(go), .score_vid(vid)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit cov(byte s, int c, int r);
    case (s)
      "a": return r == 0;
      "b": return c == 3 && r <= 3;
      "c": return c == 3 && r >= 3;
      "d": return r == 7;
      "e": return c == 0 && r >= 3;
      "f": return c == 0 && r <= 3;
      "g": return r == 3;
      default: return 0;
    endcase
  endfunction

  function automatic bit px(int hh, int vv);
    string dig[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                       "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
    int cxs[4] = '{136, 160, 264, 288};
    string segs;
    logic [4:0] sn;
    for (int i = 0; i < 4; i++) begin
      if (hh >= cxs[i] && hh < cxs[i] + 16 && vv >= 16 && vv < 48) begin
        sn = (i < 2) ? m1 : m2;
        if (i % 2 == 0) segs = sn[4] ? "bc" : "";
        else segs = (sn[3:0] <= 9) ? dig[sn[3:0]] : "";
        for (int j = 0; j < segs.len(); j++)
          if (cov(segs[j], (hh - cxs[i]) / 4, (vv - 16) / 4)) return 1;
        return 0;
      end
    end
    return 0;
  endfunction

  task automatic step(int hh, int vv, bit vbb = 0);
    bit bl, e;
    h = 9'(hh); v = 9'(vv); vb = vbb; pce = 1;
    q.push_back(px(hh, vv));
    bl = go & mfc[4];
    @(posedge clk); #1;
    if (vbb & ~mvbq) begin
      m1 = s1; m2 = s2;
      mfc = go ? mfc + 5'd1 : 5'd0;
    end else if (!go) mfc = 0;
    mvbq = vbb;
    if (q.size() == 2) begin
      e = q.pop_front() & ~bl;
      chk("pix", vid, e);
      litc += int'(vid);
    end
  endtask

  task automatic idle(int n);
    logic prev;
    pce = 0; prev = vid;
    repeat (n) begin
      @(posedge clk); #1;
      chk("hold", vid, prev);
    end
  endtask

  task automatic model_reset();
    q.delete(); m1 = 0; m2 = 0; mfc = 0; mvbq = 0;
  endtask

  task automatic frame();
    step(0, 0, 1); step(0, 0, 0);
  endtask

  task automatic scan(int x0);
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 16; c++) step(x0 + c, 16 + r);
  endtask

  initial begin
    int vis;
    rst = 1; pce = 0; vb = 0; go = 0; h = 0; v = 0; s1 = 0; s2 = 0;
    model_reset();
    @(posedge clk); #1;
    chk("rst_vid", vid, 0);
    rst = 0;
    // scores 3 and 11, spot pixels then full cell scans
    s1 = 5'd3; s2 = 5'b10001;
    frame();
    step(164, 16); step(160, 36); step(276, 32); step(264, 16); step(0, 0); step(0, 0);
    scan(136); scan(160); scan(264); scan(288);
    // mid-frame change stays hidden until next vblank edge
    s1 = 5'd5; frame();
    s1 = 5'd8;
    step(160, 36); step(160, 36); step(0, 0);
    frame();
    step(160, 36); step(0, 0); step(0, 0);
    // out-of-range BCD renders nothing
    s1 = 5'd12; frame();
    litc = 0;
    scan(136); scan(160); step(0, 0); step(0, 0);
    chk("p1_lit", litc, 0);
    // blink: 16 visible, 16 blank
    go = 1; vis = 0;
    for (int f = 0; f < 32; f++) begin
      frame(); step(276, 32); step(276, 32); step(276, 32);
      vis += int'(vid);
    end
    chk("vis_frames", vis, 16);
    for (int f = 0; f < 17; f++) begin
      frame(); step(276, 32); step(276, 32); step(276, 32);
    end
    chk("blank_phase", vid, 0);
    go = 0;
    step(276, 32);
    chk("go_drop", vid, 1);
    step(0, 0); step(0, 0);
    // latency and hold
    s2 = 5'd8; frame();
    step(0, 0); step(0, 0);
    step(288, 16);
    chk("lat1", vid, 0);
    step(0, 0);
    chk("lat2", vid, 1);
    idle(5);
    step(0, 0); step(0, 0);
    // reset mid-scan in a lit block
    s1 = 5'd8; frame();
    step(160, 16); step(160, 16);
    chk("pre_rst", vid, 1);
    rst = 1; pce = 1; h = 160; v = 16;
    @(posedge clk); #1;
    chk("rst_mid", vid, 0);
    rst = 0;
    model_reset();
    s1 = 5'd0; frame();
    scan(160); step(0, 0); step(0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
